// File: rtl/dr32e_pkg.sv
// dr32e_pkg
// Shared types and constants for the dr32e decoder slice.
//   id_seq_state_e : ID-stage sequencer states (FIRST must stay at 0 so the
//                    reset value of the state register reads as FIRST)
//   ID_SEQ_CNT_W   : width of the multicycle ALU countdown counter
package dr32e_pkg;

  localparam int ID_SEQ_CNT_W = 4;

  typedef enum logic [2:0] {
    FIRST    = 3'd0,
    LSU_GNT  = 3'd1,
    LSU_RESP = 3'd2,
    MD       = 3'd3,
    ALU_MC   = 3'd4,
    BRANCH   = 3'd5
  } id_seq_state_e;

endpackage

// File: rtl/dr32e_id_seq.sv
// dr32e_id_seq
// ID-stage sequencer. Holds the decoded instruction in ID until the resource
// it uses (LSU, multdiv, multicycle ALU, branch redirect) has completed, and
// produces first-cycle, stall, retire, RF-write gating and resource strobes.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   instr_valid_i, flush_i   IF-ID valid, controller kill of the ID instruction
//   dec_*_i, branch_taken_i  decoder class bits and branch decision (FIRST only)
//   lsu_gnt_i, lsu_resp_valid_i, lsu_err_i, multdiv_valid_i  resource handshakes
//   instr_first_cycle_o      first ID cycle of the current instruction
//   lsu_req_o, multdiv_en_o  resource requests
//   jump_set_o, branch_set_o PC redirect strobes
//   rf_we_en_o               register-file write permitted this cycle
//   instr_done_o, id_in_ready_o, stall_o  retire / handshake towards IF-ID
//   illegal_o, lsu_err_o     exception pulses
//   state_o                  FSM state for debug
module dr32e_id_seq
  import dr32e_pkg::*;
#(
  parameter int unsigned ALU_MC_CYCLES = 2,
  parameter bit          BRANCH_STALL  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       instr_valid_i,
  input  logic       flush_i,
  input  logic       dec_illegal_i,
  input  logic       dec_data_req_i,
  input  logic       dec_mult_en_i,
  input  logic       dec_div_en_i,
  input  logic       dec_alu_multicycle_i,
  input  logic       dec_jump_i,
  input  logic       dec_branch_i,
  input  logic       branch_taken_i,
  input  logic       lsu_gnt_i,
  input  logic       lsu_resp_valid_i,
  input  logic       lsu_err_i,
  input  logic       multdiv_valid_i,
  output logic       instr_first_cycle_o,
  output logic       lsu_req_o,
  output logic       multdiv_en_o,
  output logic       jump_set_o,
  output logic       branch_set_o,
  output logic       rf_we_en_o,
  output logic       instr_done_o,
  output logic       id_in_ready_o,
  output logic       stall_o,
  output logic       illegal_o,
  output logic       lsu_err_o,
  output logic [2:0] state_o
);

  localparam logic [ID_SEQ_CNT_W-1:0] CNT_LOAD = ID_SEQ_CNT_W'(ALU_MC_CYCLES - 2);

  id_seq_state_e           state_q, state_d;
  logic [ID_SEQ_CNT_W-1:0] cnt_q, cnt_d;
  logic                    flush_q, flush_d;
  logic                    accept;
  logic                    resp_killed;

  assign accept      = instr_valid_i & ~flush_i;
  // A flush seen while waiting for the LSU response is remembered so the
  // access can drain without writing the register file.
  assign resp_killed = flush_i | flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= FIRST;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  // Everything is gated by rst_ni so all outputs read 0 while reset is held,
  // even though several of them are combinational in the inputs.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    flush_d             = flush_q;
    instr_first_cycle_o = 1'b0;
    lsu_req_o           = 1'b0;
    multdiv_en_o        = 1'b0;
    jump_set_o          = 1'b0;
    branch_set_o        = 1'b0;
    rf_we_en_o          = 1'b0;
    instr_done_o        = 1'b0;
    illegal_o           = 1'b0;
    lsu_err_o           = 1'b0;
    if (rst_ni) begin
      unique case (state_q)
        FIRST: begin
          instr_first_cycle_o = accept;
          if (flush_i) begin
            instr_done_o = 1'b1;
          end else if (instr_valid_i) begin
            if (dec_illegal_i) begin
              illegal_o    = 1'b1;
              instr_done_o = 1'b1;
            end else if (dec_data_req_i) begin
              lsu_req_o = 1'b1;
              state_d   = lsu_gnt_i ? LSU_RESP : LSU_GNT;
            end else if (dec_mult_en_i | dec_div_en_i) begin
              multdiv_en_o = 1'b1;
              state_d      = MD;
            end else if (dec_alu_multicycle_i) begin
              cnt_d   = CNT_LOAD;
              state_d = ALU_MC;
            end else begin
              jump_set_o   = dec_jump_i;
              branch_set_o = dec_branch_i & branch_taken_i;
              if ((dec_jump_i | (dec_branch_i & branch_taken_i)) && BRANCH_STALL) begin
                state_d = BRANCH;
              end else begin
                instr_done_o = 1'b1;
                rf_we_en_o   = 1'b1;
              end
            end
          end
        end
        LSU_GNT: begin
          if (flush_i) begin
            instr_done_o = 1'b1;
            state_d      = FIRST;
          end else begin
            lsu_req_o = 1'b1;
            if (lsu_gnt_i) state_d = LSU_RESP;
          end
        end
        LSU_RESP: begin
          if (lsu_resp_valid_i) begin
            instr_done_o = 1'b1;
            rf_we_en_o   = ~resp_killed;
            lsu_err_o    = lsu_err_i & ~resp_killed;
            flush_d      = 1'b0;
            state_d      = FIRST;
          end else if (flush_i) begin
            flush_d = 1'b1;
          end
        end
        MD: begin
          if (flush_i) begin
            instr_done_o = 1'b1;
            state_d      = FIRST;
          end else begin
            multdiv_en_o = 1'b1;
            if (multdiv_valid_i) begin
              instr_done_o = 1'b1;
              rf_we_en_o   = 1'b1;
              state_d      = FIRST;
            end
          end
        end
        ALU_MC: begin
          if (flush_i) begin
            instr_done_o = 1'b1;
            state_d      = FIRST;
          end else if (cnt_q == '0) begin
            instr_done_o = 1'b1;
            rf_we_en_o   = 1'b1;
            state_d      = FIRST;
          end else begin
            cnt_d = cnt_q - ID_SEQ_CNT_W'(1);
          end
        end
        BRANCH: begin
          instr_done_o = 1'b1;
          rf_we_en_o   = ~flush_i;
          state_d      = FIRST;
        end
        default: begin
          state_d = FIRST;
        end
      endcase
    end
  end

  assign stall_o       = rst_ni & instr_valid_i & ~instr_done_o;
  assign id_in_ready_o = rst_ni & (instr_done_o | ((state_q == FIRST) & ~instr_valid_i));
  assign state_o       = state_q;

endmodule
